// File: rtl/apb4_cmd_master_pkg.sv
// Shared definitions for the APB4 command master: FSM encoding, APB4 response
// and protection constants, and the timeout counter width.
package apb4_cmd_master_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StSetup  = 2'd1,
      StAccess = 2'd2,
      StResp   = 2'd3
   } apb_state_e;

   // PSLVERR encoding as seen on the APB4 bus.
   localparam logic RespOkay   = 1'b0;
   localparam logic RespSlvErr = 1'b1;

   // PPROT bit positions and the idle/reset protection value.
   localparam int unsigned ProtPrivBit  = 0;
   localparam int unsigned ProtNsecBit  = 1;
   localparam int unsigned ProtInstrBit = 2;
   localparam logic [2:0]  ProtReset    = 3'b000;

   // ACCESS-phase cycle counter width.
   localparam int unsigned CntW = 16;

endpackage

// File: rtl/apb4_cmd_master.sv
// APB4 requester that turns one command-handshake transfer into one APB4 transfer
// and returns the result on a response handshake. Waits in ACCESS are bounded by
// TIMEOUT; an expired wait is reported as an error with rsp_timeout set.
module apb4_cmd_master
   import apb4_cmd_master_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_W-1:0]     cmd_addr,
   input  logic                  cmd_write,
   input  logic [DATA_W-1:0]     cmd_wdata,
   input  logic [DATA_W/8-1:0]   cmd_strb,
   input  logic [2:0]            cmd_prot,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic [ADDR_W-1:0]     paddr,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [DATA_W-1:0]     pwdata,
   output logic [DATA_W/8-1:0]   pstrb,
   output logic [2:0]            pprot,
   input  logic [DATA_W-1:0]     prdata,
   input  logic                  pready,
   input  logic                  pslverr
);

   localparam int unsigned StrbW = DATA_W / 8;
   // Count value seen during the TIMEOUT-th ACCESS cycle (counter starts at 0).
   localparam logic [CntW-1:0] LastAccess = CntW'(TIMEOUT - 1);

   apb_state_e          state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                write_q, write_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [StrbW-1:0]    strb_q, strb_d;
   logic [2:0]          prot_q, prot_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;
   logic                tout_q, tout_d;

   // State register; reset forces IDLE at once so psel/penable drop immediately.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: one SETUP cycle, ACCESS until pready or timeout, RESP until taken.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (cmd_valid) state_d = StSetup;
         StSetup:  state_d = StAccess;
         StAccess: if (pready || (cnt_q == LastAccess)) state_d = StResp;
         StResp:   if (rsp_ready) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Handshake and APB phase outputs decoded from the current state.
   always_comb begin
      cmd_ready = 1'b0;
      psel      = 1'b0;
      penable   = 1'b0;
      rsp_valid = 1'b0;
      unique case (state_q)
         StIdle:   cmd_ready = 1'b1;
         StSetup:  psel      = 1'b1;
         StAccess: begin
            psel    = 1'b1;
            penable = 1'b1;
         end
         StResp:   rsp_valid = 1'b1;
         default:  cmd_ready = 1'b0;
      endcase
   end

   // Datapath next-state: latch the command on accept, count and resolve ACCESS.
   always_comb begin
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      write_d = write_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      prot_d  = prot_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      tout_d  = tout_q;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (cmd_valid) begin
               addr_d  = cmd_addr;
               write_d = cmd_write;
               wdata_d = cmd_wdata;
               // Reads never present byte strobes on the bus.
               strb_d  = cmd_write ? cmd_strb : '0;
               prot_d  = cmd_prot;
            end
         end
         StSetup: cnt_d = '0;
         StAccess: begin
            cnt_d = cnt_q + CntW'(1);
            // pready wins over timeout on the final permitted cycle.
            if (pready) begin
               rdata_d = write_q ? '0 : prdata;
               err_d   = (pslverr == RespSlvErr);
               tout_d  = 1'b0;
            end else if (cnt_q == LastAccess) begin
               rdata_d = '0;
               err_d   = RespSlvErr;
               tout_d  = 1'b1;
            end
         end
         default: cnt_d = cnt_q;
      endcase
   end

   // Datapath registers, all cleared by reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         strb_q  <= '0;
         prot_q  <= ProtReset;
         rdata_q <= '0;
         err_q   <= RespOkay;
         tout_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
         prot_q  <= prot_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         tout_q  <= tout_d;
      end
   end

   assign paddr       = addr_q;
   assign pwrite      = write_q;
   assign pwdata      = wdata_q;
   assign pstrb       = strb_q;
   assign pprot       = prot_q;
   assign rsp_rdata   = rdata_q;
   assign rsp_err     = err_q;
   assign rsp_timeout = tout_q;

endmodule

// File: doc/apb4_cmd_master.md
APB4_CMD_MASTER -- requirements
Module: apb4_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width (STRB width = DATA_W/8).
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum ACCESS-phase cycles before abort (range 1..65535).
REQ-004 SHALL have port: clock  in  1  single clock; all logic is rising-edge.
REQ-005 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports: cmd_valid in 1, cmd_ready out 1 (command handshake); cmd_addr in ADDR_W; cmd_write in 1; cmd_wdata in DATA_W; cmd_strb in DATA_W/8; cmd_prot in 3.
REQ-007 SHALL have ports: rsp_valid out 1, rsp_ready in 1 (response handshake); rsp_rdata out DATA_W; rsp_err out 1 (PSLVERR or timeout); rsp_timeout out 1.
REQ-008 SHALL have APB4 requester ports: paddr out ADDR_W; psel out 1; penable out 1; pwrite out 1; pwdata out DATA_W; pstrb out DATA_W/8; pprot out 3; prdata in DATA_W; pready in 1; pslverr in 1.

Function
REQ-009 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-010 SHALL assert cmd_ready only in IDLE; a transfer is accepted when cmd_valid && cmd_ready.
REQ-011 SHALL, on accept, register addr/write/wdata/strb/prot and enter SETUP on the next cycle.
REQ-012 SHALL, in SETUP, drive psel=1, penable=0 for exactly one cycle, then enter ACCESS.
REQ-013 SHALL, in ACCESS, drive psel=1, penable=1 until pready=1 or timeout.
REQ-014 SHALL hold paddr, pwrite, pwdata, pstrb, pprot constant from SETUP through the final ACCESS cycle.
REQ-015 SHALL drive pstrb=0 for reads regardless of cmd_strb.
REQ-016 SHALL, on ACCESS with pready=1: capture prdata (reads) or zero (writes) into rsp_rdata, rsp_err=pslverr, rsp_timeout=0, enter RESP.
REQ-017 SHALL count ACCESS cycles with a 16-bit counter cleared on SETUP; when the count reaches TIMEOUT with pready=0, abort: rsp_rdata=0, rsp_err=1, rsp_timeout=1, enter RESP.
REQ-018 SHALL give pready=1 on the TIMEOUT-th cycle priority over timeout (normal completion).
REQ-019 SHALL deassert psel and penable in RESP and IDLE.
REQ-020 SHALL assert rsp_valid only in RESP, holding rsp_* stable until rsp_ready=1, then return to IDLE.
REQ-021 SHALL ignore pready/pslverr/prdata outside ACCESS.
REQ-022 SHALL achieve minimum latency accept->rsp_valid of 3 cycles (zero-wait slave) and throughput of one transfer per 4 cycles.

Reset
REQ-023 SHALL, on reset, enter IDLE asynchronously; outputs: cmd_ready=1 after reset release, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0, pprot=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0; counter=0.
REQ-024 SHALL, on reset mid-transfer, drop psel/penable immediately and discard the transfer (no response).

Structure
REQ-025 SHALL place FSM state encoding and APB4 response/prot constants in the shared package.
REQ-026 SHALL be implemented as a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-027 Zero-wait write: addr 0x1000_0004, wdata 0xA5A5_0001, strb 0xF, pready=1 in ACCESS -> psel rises 1 cycle after accept, penable 1 cycle later, rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
REQ-028 Read with 3 wait states: pready low 3 ACCESS cycles, prdata=0x0000_0041 -> penable held 4 cycles, pstrb=0, rsp_rdata=0x41, paddr stable throughout.
REQ-029 Slave error: read with pslverr=1, pready=1 -> rsp_err=1, rsp_timeout=0.
REQ-030 Timeout: TIMEOUT=4, pready held 0 -> abort after 4 ACCESS cycles, psel=0 next cycle, rsp_err=1, rsp_timeout=1; pready=1 on cycle 4 -> normal completion.
REQ-031 Backpressure/back-to-back: rsp_ready low 5 cycles with cmd_valid held -> rsp_* stable, cmd_ready=0; second command accepted the cycle after rsp handshake.
REQ-032 Reset asserted in ACCESS -> psel/penable=0 same cycle, rsp_valid never asserts, cmd_ready=1 after release.
